// File: rtl/tc_pkg.sv
// Shared constants for the memory-mapped down-counting timer: address map,
// CTRL bit positions, mode encodings and FSM state encoding.
package tc_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// 32-bit one-shot/auto-reload down counter with CTRL/PRESET/COUNT registers and irq.
// Reads are combinational (0 cycles); writes land on the strobe edge; no backpressure.
module timer_counter
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl;
    logic [3:0]  ctrl_d;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        flag;
    logic        flag_d;
    tc_state_e   state;
    tc_state_e   state_nxt;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;
    logic [1:0]  mode;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);
    assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_set  = 1'b0;
        flag_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl[CTRL_EN]) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET=0 lands here straight after LOAD, same as PRESET=1
                    count_nxt = '0;
                    state_nxt = INT;
                    flag_set  = 1'b1;
                end
            end
            INT: begin
                if (mode == MODE_RELOAD) begin
                    state_nxt = LOAD;
                    flag_clr  = 1'b1;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A CPU write to CTRL overrides the one-shot EN clear; expiry beats a clearing write.
    always_comb begin
        ctrl_d = ctrl;
        if (wr_ctrl) begin
            ctrl_d = wdata[3:0];
        end else if (en_clr) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end

        flag_d = flag;
        if (flag_set) begin
            flag_d = 1'b1;
        end else if (wr_ctrl || wr_preset || flag_clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            state  <= IDLE;
            flag   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            ctrl   <= ctrl_d;
            if (wr_preset) begin
                preset <= wdata;
            end
            count  <= count_nxt;
            state  <= state_nxt;
            flag   <= flag_d;
            irq    <= flag_d & ctrl_d[CTRL_IM];
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = '0;
        endcase
    end

endmodule
